// File: rtl/skiroc_emu_pkg.sv
// Shared types and widths for the SKIROC ASIC emulator: FSM states, field widths
// and the readout word packing.
package skiroc_emu_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACQ       = 3'd1,
    HOLD      = 3'd2,
    CONV      = 3'd3,
    CONVERTED = 3'd4,
    READ      = 3'd5,
    ENDRD     = 3'd6
  } state_e;

  localparam int BCID_W      = 12;
  localparam int CELL_ID_W   = 4;
  localparam int WORD_W      = 16;
  localparam int HDR_W       = 8;
  localparam int FRAME_CNT_W = $clog2(HDR_W + WORD_W * 15);
  localparam int SER_LEN_W   = $clog2(WORD_W + 1);

  // One readout word: cell index in the top nibble, stored timestamp below.
  function automatic logic [WORD_W-1:0] cell_word(input logic [CELL_ID_W-1:0] id,
                                                  input logic [BCID_W-1:0] bcid);
    return {id, bcid};
  endfunction

endpackage

// File: rtl/skiroc_emu_if.sv
// Controller <-> emulated ASIC strobes and serial readout lines.
interface skiroc_emu_if;

  logic In_Resetb_ASIC;
  logic In_Start_Acq;
  logic In_Start_Convb;
  logic In_Start_Readout;
  logic In_Trigger;
  logic Out_Chipsatb;
  logic Out_End_Readout;
  logic Out_Dout;
  logic Out_Transmiton;
  logic Out_Busy;

  modport master (
    output In_Resetb_ASIC, In_Start_Acq, In_Start_Convb, In_Start_Readout, In_Trigger,
    input  Out_Chipsatb, Out_End_Readout, Out_Dout, Out_Transmiton, Out_Busy
  );

  modport slave (
    input  In_Resetb_ASIC, In_Start_Acq, In_Start_Convb, In_Start_Readout, In_Trigger,
    output Out_Chipsatb, Out_End_Readout, Out_Dout, Out_Transmiton, Out_Busy
  );

endinterface

// File: rtl/skiroc_emu_serializer.sv
// Loads one word (header or cell) and shifts its top len bits out MSB first;
// word_done marks the cycle carrying the last bit so the next load is seamless.
module skiroc_emu_serializer
  import skiroc_emu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 srst,
  input  logic                 load,
  input  logic [WORD_W-1:0]    word,
  input  logic [SER_LEN_W-1:0] len,
  output logic                 dout,
  output logic                 valid,
  output logic                 word_done
);

  logic [WORD_W-1:0]    shift_r;
  logic [SER_LEN_W-1:0] cnt_r;
  logic                 dout_r;
  logic                 valid_r;

  // Shift register; cnt_r holds the bits still to follow the one on dout_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= '0;
      cnt_r   <= '0;
      dout_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (srst) begin
      shift_r <= '0;
      cnt_r   <= '0;
      dout_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (load) begin
      dout_r  <= word[WORD_W-1];
      shift_r <= {word[WORD_W-2:0], 1'b0};
      cnt_r   <= len - SER_LEN_W'(1);
      valid_r <= 1'b1;
    end else if (cnt_r != '0) begin
      dout_r  <= shift_r[WORD_W-1];
      shift_r <= {shift_r[WORD_W-2:0], 1'b0};
      cnt_r   <= cnt_r - SER_LEN_W'(1);
      valid_r <= 1'b1;
    end else begin
      dout_r  <= 1'b0;
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
      valid_r <= 1'b0;
    end
  end

  assign dout      = dout_r;
  assign valid     = valid_r;
  assign word_done = valid_r && (cnt_r == '0);

endmodule

// File: rtl/skiroc_asic_emulator.sv
// Behavioural SKIROC stand-in: timestamps triggers into an emulated SCA,
// converts on command and serialises header plus stored cells on readout.
module skiroc_asic_emulator
  import skiroc_emu_pkg::*;
#(
  parameter int         SCA_DEPTH   = 15,
  parameter logic [7:0] CHIP_ID     = 8'hA5,
  parameter int         CONV_CYCLES = 200
) (
  input logic          Clk,
  input logic          Rst_N,
  skiroc_emu_if.slave  bus
);

  localparam logic [CELL_ID_W-1:0] DEPTH_C     = CELL_ID_W'(SCA_DEPTH);
  localparam int                   CONV_W      = $clog2(CONV_CYCLES + 1);
  localparam logic [CONV_W-1:0]    CONV_LAST_C = CONV_W'(CONV_CYCLES - 1);

  logic [1:0] resetb_sync_r, acq_sync_r, convb_sync_r, rdo_sync_r, trig_sync_r;
  logic       rdo_dly_r, trig_dly_r;
  logic       srst_s, acq_s, conv_s, rdo_rise_s, trig_rise_s;

  state_e                 state_r, state_next;
  logic [BCID_W-1:0]      bcid_r;
  logic [BCID_W-1:0]      cell_r [SCA_DEPTH];
  logic [CELL_ID_W-1:0]   count_r, idx_r;
  logic [CONV_W-1:0]      conv_cnt_r;
  logic [FRAME_CNT_W-1:0] bits_left_r, frame_len_s;
  logic                   started_r, chipsatb_r, end_readout_r, busy_r;
  logic                   store_s, ser_load_s, ser_dout_s, ser_valid_s, ser_done_s;
  logic [WORD_W-1:0]      ser_word_s;
  logic [SER_LEN_W-1:0]   ser_len_s;

  // Two-flop synchronisers plus one delay stage for rising-edge detection.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      resetb_sync_r <= 2'b00;
      acq_sync_r    <= 2'b00;
      convb_sync_r  <= 2'b11;
      rdo_sync_r    <= 2'b00;
      trig_sync_r   <= 2'b00;
      rdo_dly_r     <= 1'b0;
      trig_dly_r    <= 1'b0;
    end else begin
      resetb_sync_r <= {resetb_sync_r[0], bus.In_Resetb_ASIC};
      acq_sync_r    <= {acq_sync_r[0], bus.In_Start_Acq};
      convb_sync_r  <= {convb_sync_r[0], bus.In_Start_Convb};
      rdo_sync_r    <= {rdo_sync_r[0], bus.In_Start_Readout};
      trig_sync_r   <= {trig_sync_r[0], bus.In_Trigger};
      rdo_dly_r     <= rdo_sync_r[1];
      trig_dly_r    <= trig_sync_r[1];
    end
  end

  assign srst_s      = ~resetb_sync_r[1];
  assign acq_s       = acq_sync_r[1];
  assign conv_s      = ~convb_sync_r[1];
  assign rdo_rise_s  = rdo_sync_r[1] & ~rdo_dly_r;
  assign trig_rise_s = trig_sync_r[1] & ~trig_dly_r;
  assign frame_len_s = FRAME_CNT_W'(HDR_W) + FRAME_CNT_W'({count_r, 4'b0000});

  // Free-running timestamp; only the board reset clears it.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      bcid_r <= '0;
    end else begin
      bcid_r <= bcid_r + BCID_W'(1);
    end
  end

  // Next state and serializer feed.
  always_comb begin
    state_next = state_r;
    store_s    = 1'b0;
    ser_load_s = 1'b0;
    ser_word_s = '0;
    ser_len_s  = '0;
    if (srst_s) begin
      state_next = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (acq_s) state_next = ACQ;
          else       state_next = IDLE;
        end
        ACQ: begin
          if (trig_rise_s && (count_r != DEPTH_C)) store_s = 1'b1;
          else                                     store_s = 1'b0;
          if (!acq_s) state_next = HOLD;
          else        state_next = ACQ;
        end
        HOLD: begin
          if (conv_s)     state_next = CONV;
          else if (acq_s) state_next = ACQ;
          else            state_next = HOLD;
        end
        CONV: begin
          if (conv_cnt_r == CONV_LAST_C) state_next = CONVERTED;
          else                           state_next = CONV;
        end
        CONVERTED: begin
          if (rdo_rise_s) state_next = READ;
          else            state_next = CONVERTED;
        end
        READ: begin
          if (!started_r) begin
            ser_load_s = 1'b1;
            ser_word_s = {CHIP_ID, 8'h00};
            ser_len_s  = SER_LEN_W'(HDR_W);
          end else if (ser_done_s) begin
            if (bits_left_r == FRAME_CNT_W'(1)) begin
              state_next = ENDRD;
            end else begin
              ser_load_s = 1'b1;
              ser_word_s = cell_word(idx_r, cell_r[idx_r]);
              ser_len_s  = SER_LEN_W'(WORD_W);
            end
          end else begin
            state_next = READ;
          end
        end
        ENDRD:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register, SCA storage, readout sequencing and registered flags.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_r       <= IDLE;
      count_r       <= '0;
      idx_r         <= '0;
      started_r     <= 1'b0;
      bits_left_r   <= '0;
      conv_cnt_r    <= '0;
      chipsatb_r    <= 1'b1;
      end_readout_r <= 1'b0;
      busy_r        <= 1'b0;
      for (int i = 0; i < SCA_DEPTH; i++) cell_r[i] <= '0;
    end else begin
      state_r       <= state_next;
      busy_r        <= (state_next != IDLE);
      end_readout_r <= (state_next == ENDRD);
      if (srst_s || (state_next == ENDRD)) begin
        count_r    <= '0;
        chipsatb_r <= 1'b1;
      end else begin
        if (store_s) begin
          cell_r[count_r] <= bcid_r;
          count_r         <= count_r + CELL_ID_W'(1);
        end else begin
          count_r <= count_r;
        end
        chipsatb_r <= (count_r != DEPTH_C);
      end
      if (state_r == CONV) conv_cnt_r <= conv_cnt_r + CONV_W'(1);
      else                 conv_cnt_r <= '0;
      // Outside READ the frame length tracks the count, so it is ready on entry.
      if (state_r != READ) begin
        started_r   <= 1'b0;
        idx_r       <= '0;
        bits_left_r <= frame_len_s;
      end else begin
        if (ser_load_s) started_r <= 1'b1;
        else            started_r <= started_r;
        if (ser_load_s && started_r) idx_r <= idx_r + CELL_ID_W'(1);
        else                         idx_r <= idx_r;
        if (ser_valid_s) bits_left_r <= bits_left_r - FRAME_CNT_W'(1);
        else             bits_left_r <= bits_left_r;
      end
    end
  end

  skiroc_emu_serializer u_ser (
    .clk       (Clk),
    .rst_n     (Rst_N),
    .srst      (srst_s),
    .load      (ser_load_s),
    .word      (ser_word_s),
    .len       (ser_len_s),
    .dout      (ser_dout_s),
    .valid     (ser_valid_s),
    .word_done (ser_done_s)
  );

  assign bus.Out_Chipsatb    = chipsatb_r;
  assign bus.Out_End_Readout = end_readout_r;
  assign bus.Out_Dout        = ser_dout_s;
  assign bus.Out_Transmiton  = ser_valid_s;
  assign bus.Out_Busy        = busy_r;

endmodule

// File: tb/tb_skiroc_asic_emulator.sv
// Directed-plus-random bench for the SKIROC emulator; a queue of expected
// timestamps models the SCA and the expected readout frame is built from it.
module tb_skiroc_asic_emulator;

  localparam int DEPTH  = 15;
  localparam int CONV_N = 200;

  logic Clk = 1'b0;
  logic Rst_N;
  always #10 Clk = ~Clk;

  skiroc_emu_if bus();

  skiroc_asic_emulator #(.SCA_DEPTH(DEPTH), .CHIP_ID(8'hA5), .CONV_CYCLES(CONV_N)) dut (
    .Clk   (Clk),
    .Rst_N (Rst_N),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int q[$];

  // Clock edges since reset release == expected BCID value after that edge.
  always @(posedge Clk) if (Rst_N) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: observed time-out, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge Clk);
  endtask

  // A hit is timestamped with the BCID two edges after it is driven.
  task automatic trig(input bit in_acq, input int gap);
    int old_n, new_n;
    old_n = q.size();
    bus.In_Trigger = 1'b1;
    if (in_acq && q.size() < DEPTH) q.push_back((cyc + 2) % 4096);
    new_n = q.size();
    tick(2);
    bus.In_Trigger = 1'b0;
    tick(1);
    chk("chipsatb_pre", bus.Out_Chipsatb, old_n != DEPTH);
    tick(1);
    chk("chipsatb_post", bus.Out_Chipsatb, new_n != DEPTH);
    tick(gap);
  endtask

  task automatic start_acq();
    bus.In_Start_Acq = 1'b1;
    tick(4);
    chk("busy_acq", bus.Out_Busy, 1'b1);
  endtask

  task automatic stop_acq();
    bus.In_Start_Acq = 1'b0;
    tick(4);
    chk("busy_hold", bus.Out_Busy, 1'b1);
  endtask

  task automatic convert(input bit with_acq, input int n_ign);
    int k;
    k = cyc;
    bus.In_Start_Convb = 1'b0;
    if (with_acq) bus.In_Start_Acq = 1'b1;
    tick(2);
    bus.In_Start_Convb = 1'b1;
    bus.In_Start_Acq   = 1'b0;
    tick(1);
    for (int i = 0; i < n_ign; i++) trig(1'b0, $urandom_range(0, 5));
    chk("busy_conv", bus.Out_Busy, 1'b1);
    wait_cyc(k + CONV_N - 6);
    bus.In_Start_Readout = 1'b1;
    tick(4);
    chk("rdo_in_conv_ignored", bus.Out_Transmiton, 1'b0);
    bus.In_Start_Readout = 1'b0;
    wait_cyc(k + CONV_N + 8);
  endtask

  task automatic do_readout(input int abort_at);
    logic [255:0] got, exp;
    int ng, ne, k;
    bit seen, aborted;
    exp = 256'h0A5;
    ne  = 8;
    foreach (q[i]) begin
      exp = (exp << 16) | 256'((i << 12) | q[i]);
      ne += 16;
    end
    got = '0; ng = 0; seen = 1'b0; aborted = 1'b0;
    k = cyc;
    bus.In_Start_Readout = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick(1);
      if (bus.Out_Transmiton === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("tx_start", seen, 1'b1);
    if (seen) begin
      chk("tx_latency", cyc - k, 4);
      while (bus.Out_Transmiton === 1'b1 && ng < 300) begin
        got = (got << 1) | 256'(bus.Out_Dout);
        ng++;
        chk("end_early", bus.Out_End_Readout, 1'b0);
        if (abort_at != 0 && ng == abort_at) begin
          aborted = 1'b1;
          break;
        end
        tick(1);
      end
      if (aborted) begin
        bus.In_Resetb_ASIC = 1'b0;
        for (int t = 0; t < 3; t++) begin
          tick(1);
          chk("abort_no_end", bus.Out_End_Readout, 1'b0);
        end
        chk("abort_tx", bus.Out_Transmiton, 1'b0);
        chk("abort_dout", bus.Out_Dout, 1'b0);
        chk("abort_busy", bus.Out_Busy, 1'b0);
        chk("abort_chipsatb", bus.Out_Chipsatb, 1'b1);
        bus.In_Resetb_ASIC = 1'b1;
        tick(4);
      end else begin
        chk("frame_len", ng, ne);
        chk("frame_data", got, exp);
        chk("end_pulse", bus.Out_End_Readout, 1'b1);
        chk("chipsatb_end", bus.Out_Chipsatb, 1'b1);
        chk("dout_idle", bus.Out_Dout, 1'b0);
        tick(1);
        chk("end_pulse_width", bus.Out_End_Readout, 1'b0);
        chk("busy_idle", bus.Out_Busy, 1'b0);
      end
    end
    bus.In_Start_Readout = 1'b0;
    q.delete();
    tick(2);
  endtask

  initial begin
    int n;
    bus.In_Resetb_ASIC   = 1'b1;
    bus.In_Start_Acq     = 1'b0;
    bus.In_Start_Convb   = 1'b1;
    bus.In_Start_Readout = 1'b0;
    bus.In_Trigger       = 1'b0;
    Rst_N = 1'b0;

    #90;
    chk("rst_chipsatb", bus.Out_Chipsatb, 1'b1);
    chk("rst_end", bus.Out_End_Readout, 1'b0);
    chk("rst_dout", bus.Out_Dout, 1'b0);
    chk("rst_tx", bus.Out_Transmiton, 1'b0);
    chk("rst_busy", bus.Out_Busy, 1'b0);
    @(negedge Clk);
    Rst_N = 1'b1;
    tick(1);
    chk("post_rst_chipsatb", bus.Out_Chipsatb, 1'b1);
    chk("post_rst_busy", bus.Out_Busy, 1'b0);

    // Basic flow: hits timestamped 40, 90, 150.
    start_acq();
    wait_cyc(38);  trig(1'b1, 0);
    wait_cyc(88);  trig(1'b1, 0);
    wait_cyc(148); trig(1'b1, 0);
    stop_acq();
    convert(1'b0, 0);
    do_readout(0);

    // Zero events; Start_Acq and Start_Convb together in HOLD, hits during CONV.
    start_acq();
    stop_acq();
    convert(1'b1, 2);
    do_readout(0);

    // Saturation: 17 hits, the last two dropped.
    start_acq();
    repeat (17) trig(1'b1, $urandom_range(0, 12));
    stop_acq();
    convert(1'b0, 0);
    do_readout(0);

    // Functional reset in the middle of a readout.
    start_acq();
    n = $urandom_range(2, 6);
    repeat (n) trig(1'b1, $urandom_range(0, 20));
    stop_acq();
    convert(1'b0, 0);
    do_readout(20);

    // Fresh acquisition across the BCID wrap, with ignored strobes and HOLD resume.
    wait_cyc(4070);
    start_acq();
    n = $urandom_range(1, 5);
    repeat (n) trig(1'b1, $urandom_range(0, 6));
    bus.In_Start_Readout = 1'b1;
    tick(5);
    chk("rdo_in_acq_tx", bus.Out_Transmiton, 1'b0);
    chk("rdo_in_acq_busy", bus.Out_Busy, 1'b1);
    bus.In_Start_Readout = 1'b0;
    tick(3);
    stop_acq();
    start_acq();
    n = $urandom_range(1, 4);
    repeat (n) trig(1'b1, $urandom_range(0, 6));
    stop_acq();
    convert(1'b0, 3);
    do_readout(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
